// File: rtl/hdb3_pkg.sv
// hdb3_pkg: shared definitions for the HDB3 receive path.
//   SYM_* : two-rail line symbol encodings (positive/negative rail per bit).
//   pol_e : pulse polarity, used for both last-pulse and last-V tracking.
package hdb3_pkg;

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_POS  = 2'b01;
  localparam logic [1:0] SYM_NEG  = 2'b10;
  localparam logic [1:0] SYM_ILL  = 2'b11;

  typedef enum logic {
    POL_POS = 1'b0,
    POL_NEG = 1'b1
  } pol_e;

endpackage

// File: rtl/hdb3_los_det.sv
// hdb3_los_det: zero-run tracking for the HDB3 decoder.
//   clk, rst_n : clock, async active-low reset
//   mark_i     : current symbol is a pulse (zero symbols are 00 and 11)
//   los_o      : registered loss-of-signal flag (1 out of reset)
//   z4_err_o   : combinational strobe, 4th consecutive zero while los_o=0
module hdb3_los_det #(
  parameter int unsigned LOS_ZEROS = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mark_i,
  output logic los_o,
  output logic z4_err_o
);

  localparam logic [7:0] LOS_M1 = 8'(LOS_ZEROS - 1);

  logic [7:0] zrun_q, zrun_d;
  logic       los_q, los_d;

  always_comb begin
    zrun_d   = zrun_q;
    los_d    = los_q;
    z4_err_o = 1'b0;
    if (mark_i) begin
      zrun_d = '0;
      los_d  = 1'b0;
    end else begin
      if (zrun_q != '1) zrun_d = zrun_q + 8'd1;
      // LOS asserts on the edge the count reaches LOS_ZEROS
      if (zrun_q == LOS_M1) los_d = 1'b1;
      // HDB3 never carries four zeros in a row; flag only while locked
      if (zrun_q == 8'd3 && !los_q) z4_err_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zrun_q <= '0;
      los_q  <= 1'b1;
    end else begin
      zrun_q <= zrun_d;
      los_q  <= los_d;
    end
  end

  assign los_o = los_q;

endmodule

// File: rtl/hdb3_decode.sv
// hdb3_decode: HDB3 line decoder.
//   clk, rst_n : clock, async active-low reset
//   line_in    : two-rail symbol (01 pos, 10 neg, 00 zero, 11 illegal)
//   err_clr    : synchronous clear of err_cnt (wins over increment)
//   dout       : recovered NRZ bit, 3 edges after its symbol is sampled
//   err        : one-cycle registered code-error pulse
//   err_cnt    : saturating error count
//   los        : loss of signal
module hdb3_decode
  import hdb3_pkg::*;
#(
  parameter int unsigned LOS_ZEROS = 32,
  parameter int unsigned ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       line_in,
  input  logic             err_clr,
  output logic             dout,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             los
);

  logic             mark, ill, is_v, alt_err, z4_err;
  pol_e             pol;

  logic [3:0]       d_q, d_d;
  pol_e             last_pol_q, last_pol_d, lastv_pol_q, lastv_pol_d;
  logic             pol_valid_q, pol_valid_d, v_seen_q, v_seen_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  assign mark    = (line_in == SYM_POS) || (line_in == SYM_NEG);
  assign ill     = (line_in == SYM_ILL);
  assign pol     = (line_in == SYM_NEG) ? POL_NEG : POL_POS;
  assign is_v    = mark && pol_valid_q && (pol == last_pol_q);
  assign alt_err = is_v && v_seen_q && (pol == lastv_pol_q);

  hdb3_los_det #(
    .LOS_ZEROS(LOS_ZEROS)
  ) u_los (
    .clk     (clk),
    .rst_n   (rst_n),
    .mark_i  (mark),
    .los_o   (los),
    .z4_err_o(z4_err)
  );

  always_comb begin
    last_pol_d  = last_pol_q;
    pol_valid_d = pol_valid_q;
    lastv_pol_d = lastv_pol_q;
    v_seen_d    = v_seen_q;
    err_cnt_d   = err_cnt_q;
    // A violation wipes itself and the three symbols before it, which
    // removes both 000V and B00V substitutions from the stream.
    d_d         = is_v ? '0 : {d_q[2:0], mark};

    if (mark) begin
      last_pol_d  = pol;
      pol_valid_d = 1'b1;
    end
    if (is_v) begin
      lastv_pol_d = pol;
      v_seen_d    = 1'b1;
    end

    err_d = ill || alt_err || z4_err;

    if (err_clr)                     err_cnt_d = '0;
    else if (err_d && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q         <= '0;
      last_pol_q  <= POL_POS;
      pol_valid_q <= 1'b0;
      lastv_pol_q <= POL_POS;
      v_seen_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      d_q         <= d_d;
      last_pol_q  <= last_pol_d;
      pol_valid_q <= pol_valid_d;
      lastv_pol_q <= lastv_pol_d;
      v_seen_q    <= v_seen_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign dout    = d_q[3];
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_hdb3_decode.sv
module tb_hdb3_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  line_in = 2'b00;
  logic        err_clr = 1'b0;
  logic        dout, err, los;
  logic [15:0] err_cnt;
  logic        dout4, err4, los4;
  logic [3:0]  err_cnt4;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  hdb3_decode #(.LOS_ZEROS(32), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .line_in(line_in), .err_clr(err_clr),
    .dout(dout), .err(err), .err_cnt(err_cnt), .los(los)
  );

  hdb3_decode #(.LOS_ZEROS(32), .ERR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .line_in(line_in), .err_clr(err_clr),
    .dout(dout4), .err(err4), .err_cnt(err_cnt4), .los(los4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one symbol mid-cycle, sample 1 time unit after the capturing edge
  task automatic step(input logic [1:0] sym, input logic clr);
    @(negedge clk);
    line_in = sym;
    err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    line_in = 2'b00;
    err_clr = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // ---------------- reset state
    do_reset();
    chk("rst_dout", dout, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_los", los, 1);

    // ---------------- AMI: 01,00,10,10 (4th is a V, no error)
    step(2'b01, 0); chk("ami1_los", los, 0); chk("ami1_dout", dout, 0);
    step(2'b00, 0); chk("ami2_dout", dout, 0);
    step(2'b10, 0); chk("ami3_dout", dout, 0);
    step(2'b10, 0); chk("ami4_dout", dout, 0); chk("ami4_err", err, 0);
    step(2'b01, 0); chk("ami5_dout", dout, 0);
    step(2'b10, 0); chk("ami6_dout", dout, 0); chk("ami6_cnt", err_cnt, 0);

    // ---------------- B00V: 01,10,01,00,00,01 then 10,01,10,01
    do_reset();
    step(2'b01, 0); chk("b1_dout", dout, 0);
    step(2'b10, 0); chk("b2_dout", dout, 0);
    step(2'b01, 0); chk("b3_dout", dout, 0);
    step(2'b00, 0); chk("b4_dout", dout, 1);
    step(2'b00, 0); chk("b5_dout", dout, 1);
    step(2'b01, 0); chk("b6_dout", dout, 0); chk("b6_err", err, 0);
    step(2'b10, 0); chk("b7_dout", dout, 0);
    step(2'b01, 0); chk("b8_dout", dout, 0);
    step(2'b10, 0); chk("b9_dout", dout, 0);
    step(2'b01, 0); chk("b10_dout", dout, 1); chk("b10_cnt", err_cnt, 0);

    // ---------------- 000V alternation, then repeated V+ polarity
    do_reset();
    step(2'b01, 0);
    step(2'b00, 0);
    step(2'b00, 0);
    step(2'b00, 0); chk("v4_dout", dout, 1); chk("v4_err", err, 0);
    step(2'b01, 0); chk("v5_dout", dout, 0); chk("v5_err", err, 0);
    step(2'b10, 0);
    step(2'b00, 0);
    step(2'b00, 0);
    step(2'b00, 0); chk("v9_dout", dout, 1);
    step(2'b10, 0); chk("v10_dout", dout, 0); chk("v10_err", err, 0);
    step(2'b01, 0);
    step(2'b00, 0);
    step(2'b00, 0);
    step(2'b00, 0);
    step(2'b01, 0); chk("v15_err", err, 0); chk("v15_cnt", err_cnt, 0);
    step(2'b10, 0);
    step(2'b01, 0);
    step(2'b00, 0);
    step(2'b00, 0); chk("v19_err", err, 0);
    step(2'b01, 0); chk("v20_err", err, 1); chk("v20_cnt", err_cnt, 1);
    step(2'b10, 0); chk("v21_err", err, 0); chk("v21_cnt", err_cnt, 1);

    // ---------------- illegal symbol, 4-zero run, clear vs increment
    step(2'b11, 0); chk("ill_err", err, 1); chk("ill_cnt", err_cnt, 2);
    step(2'b01, 0); chk("ill_next_err", err, 0);
    step(2'b00, 0); chk("z1_err", err, 0);
    step(2'b00, 0); chk("z2_err", err, 0);
    step(2'b00, 0); chk("z3_err", err, 0);
    step(2'b00, 0); chk("z4_err", err, 1); chk("z4_cnt", err_cnt, 3);
    step(2'b00, 0); chk("z5_err", err, 0); chk("z5_cnt", err_cnt, 3);
    step(2'b11, 1); chk("clr_err", err, 1); chk("clr_cnt", err_cnt, 0);
    step(2'b10, 0); chk("clr_next_err", err, 0); chk("clr_next_cnt", err_cnt, 0);

    // ---------------- LOS
    do_reset();
    chk("los_rst", los, 1);
    step(2'b01, 0); chk("los_pulse", los, 0);
    for (int i = 1; i <= 31; i++) step(2'b00, 0);
    chk("los_31", los, 0);
    chk("los_zcnt", err_cnt, 1);
    step(2'b00, 0); chk("los_32", los, 1);
    step(2'b10, 0); chk("los_clear", los, 0);

    // ---------------- saturation with ERR_W=4 (and 16-bit reference)
    do_reset();
    for (int i = 0; i < 20; i++) step(2'b11, 0);
    chk("sat4_cnt", err_cnt4, 15);
    chk("sat16_cnt", err_cnt, 20);
    chk("sat_err", err, 1);

    // ---------------- reset mid-stream
    step(2'b01, 0);
    step(2'b10, 0);
    step(2'b01, 0);
    step(2'b10, 0); chk("mid_pre_dout", dout, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_dout", dout, 0);
    chk("mid_cnt", err_cnt, 0);
    chk("mid_los", los, 1);
    chk("mid_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // first pulse after reset re-learns polarity: 01 is data, not a V
    step(2'b01, 0); chk("relearn_err", err, 0);
    step(2'b10, 0);
    step(2'b01, 0);
    step(2'b10, 0); chk("relearn_dout", dout, 1); chk("relearn_cnt", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running required finished");
    $fatal(1, "timeout");
  end

endmodule
